// File: rtl/pool2d_stream_pkg.sv
// Shared definitions for the streaming 2-D pooling engine: width helpers,
// FSM state encoding and the per-frame reduction mode constants.
package pool_pkg;

  // Reduction mode, latched on the first pixel of every frame.
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pool_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Accumulator width: room for the sum of POOL_K*POOL_K pixels.
  function automatic int acc_width(input int data_w, input int pool_k);
    return data_w + 2 * clog2(pool_k);
  endfunction

endpackage

// File: rtl/pool2d_stream_reduce_unit.sv
// Combinational window reduction step: folds one pixel into a running
// accumulator (max or sum) and forms the final window result.
module pool_reduce_unit
  import pool_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int POOL_K = 2,
  parameter int SIGNED = 1,
  parameter int ACC_W  = acc_width(DATA_W, POOL_K)
) (
  input  logic              first_pix,
  input  logic              mode,
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] pixel,
  output logic [ACC_W-1:0]  acc_next,
  output logic [DATA_W-1:0] result
);

  localparam int SHIFT = 2 * clog2(POOL_K);
  localparam int EXT_W = ACC_W - DATA_W;

  logic [ACC_W-1:0] pix_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic [ACC_W-1:0] max_s;
  logic [ACC_W-1:0] avg_s;
  logic             pix_gt_s;

  // Extend the pixel, compute candidate max/sum and the divided average.
  always_comb begin
    pix_ext_s = {ACC_W{1'b0}};
    pix_gt_s  = 1'b0;
    avg_s     = {ACC_W{1'b0}};
    if (SIGNED != 0) begin
      pix_ext_s = {{EXT_W{pixel[DATA_W-1]}}, pixel};
      pix_gt_s  = $signed(pix_ext_s) > $signed(acc);
    end else begin
      pix_ext_s = {{EXT_W{1'b0}}, pixel};
      pix_gt_s  = pix_ext_s > acc;
    end
    sum_s = acc + pix_ext_s;
    max_s = pix_gt_s ? pix_ext_s : acc;
    // Arithmetic shift in signed mode so the average rounds toward -inf.
    if (SIGNED != 0) begin
      avg_s = $signed(sum_s) >>> SHIFT;
    end else begin
      avg_s = sum_s >> SHIFT;
    end
  end

  // Select the new accumulator value and the window result for the mode.
  always_comb begin
    acc_next = {ACC_W{1'b0}};
    result   = {DATA_W{1'b0}};
    if (first_pix) begin
      acc_next = pix_ext_s;
    end else if (mode == POOL_AVG) begin
      acc_next = sum_s;
    end else begin
      acc_next = max_s;
    end
    if (mode == POOL_AVG) begin
      result = avg_s[DATA_W-1:0];
    end else begin
      result = max_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2-D pooling engine. Pixels arrive in raster order; each
// non-overlapping POOL_K x POOL_K window is reduced to one max or average.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int POOL_K = 2,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int ACC_W  = acc_width(DATA_W, POOL_K);
  localparam int LOG_K  = clog2(POOL_K);
  localparam int NSLOT  = IMG_W / POOL_K;
  localparam int COL_W  = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int ROW_W  = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  localparam int SLOT_W = (clog2(NSLOT) > 0) ? clog2(NSLOT) : 1;

  pool_state_t       state_r;
  pool_state_t       state_nxt_s;
  logic              mode_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [ACC_W-1:0]  acc_r [NSLOT];
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              handoff_s;
  logic              col_last_s;
  logic              row_last_s;
  logic              first_pix_s;
  logic              win_done_s;
  logic              frame_start_s;
  logic              frame_end_s;
  logic [SLOT_W-1:0] slot_s;
  logic [ACC_W-1:0]  acc_next_s;
  logic [DATA_W-1:0] result_s;

  // Handshake qualifiers and raster-position decodes.
  always_comb begin
    in_ready_s    = !(out_valid_r && !out_ready);
    accept_s      = in_valid && in_ready_s;
    handoff_s     = out_valid_r && out_ready;
    col_last_s    = (col_r == COL_W'(IMG_W - 1));
    row_last_s    = (row_r == ROW_W'(IMG_H - 1));
    first_pix_s   = (col_r[LOG_K-1:0] == {LOG_K{1'b0}}) &&
                    (row_r[LOG_K-1:0] == {LOG_K{1'b0}});
    win_done_s    = (col_r[LOG_K-1:0] == {LOG_K{1'b1}}) &&
                    (row_r[LOG_K-1:0] == {LOG_K{1'b1}});
    frame_start_s = accept_s && (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
    frame_end_s   = accept_s && col_last_s && row_last_s;
    slot_s        = SLOT_W'(col_r >> LOG_K);
  end

  pool_reduce_unit #(
    .DATA_W (DATA_W),
    .POOL_K (POOL_K),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W)
  ) u_reduce (
    .first_pix (first_pix_s),
    .mode      (mode_r),
    .acc       (acc_r[slot_s]),
    .pixel     (in_data),
    .acc_next  (acc_next_s),
    .result    (result_s)
  );

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next state. A pixel accepted during the final hand-off
  // already belongs to the next frame, so DRAIN can go straight to RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (handoff_s && accept_s) begin
          state_nxt_s = ST_RUN;
        end else if (handoff_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Raster counters and the per-frame mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r  <= {COL_W{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      mode_r <= POOL_MAX;
    end else if (accept_s) begin
      if (frame_start_s) begin
        mode_r <= mode;
      end else begin
        mode_r <= mode_r;
      end
      if (col_last_s) begin
        col_r <= {COL_W{1'b0}};
        row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
        row_r <= row_r;
      end
    end else begin
      col_r  <= col_r;
      row_r  <= row_r;
      mode_r <= mode_r;
    end
  end

  // Column-slot accumulators, one per window across the image width.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NSLOT; j++) begin
        acc_r[j] <= {ACC_W{1'b0}};
      end
    end else if (accept_s) begin
      acc_r[slot_s] <= acc_next_s;
    end else begin
      acc_r[slot_s] <= acc_r[slot_s];
    end
  end

  // Output register: loads on the last pixel of a window, holds until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (accept_s && win_done_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (handoff_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  // Port drive; frame_done marks the hand-off of the frame's last result.
  always_comb begin
    in_ready   = in_ready_s;
    out_valid  = out_valid_r;
    out_data   = out_data_r;
    frame_done = (state_r == ST_DRAIN) && handoff_s;
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream with default geometry (8x8, K=2,
// signed). A reference model pools whole frames with plain arithmetic.
module tb_pool2d_stream;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_data;
  logic        frame_done;

  int          checks;
  int          failures;
  logic [21:0] got[$];
  int          fd_count;
  int          fd_hs_idx[$];

  pool2d_stream #(
    .DATA_W (22),
    .IMG_W  (8),
    .IMG_H  (8),
    .POOL_K (2),
    .SIGNED (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output hand-off and frame_done pulse (sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
    if (!rst && frame_done) begin
      fd_count++;
      fd_hs_idx.push_back(got.size());
    end
  end

  function automatic longint sx(input logic [21:0] p);
    longint v;
    v = longint'(p);
    if (p[21]) v = v - 64'sd4194304;
    return v;
  endfunction

  // Reference: pool each 2x2 window of an 8x8 frame in window raster order.
  function automatic void model_frame(input logic [21:0] px[64], input logic m,
                                      output logic [21:0] res[16]);
    for (int wi = 0; wi < 4; wi++) begin
      for (int wj = 0; wj < 4; wj++) begin
        longint best, sum, q, v;
        logic [63:0] t;
        best = sx(px[(2*wi)*8 + 2*wj]);
        sum  = 0;
        for (int a = 0; a < 2; a++) begin
          for (int b = 0; b < 2; b++) begin
            v = sx(px[(2*wi+a)*8 + 2*wj+b]);
            sum = sum + v;
            if (v > best) best = v;
          end
        end
        q = sum / 4;
        if ((sum % 4 != 0) && (sum < 0)) q = q - 1;
        t = m ? q : best;
        res[wi*4+wj] = t[21:0];
      end
    end
  endfunction

  function automatic void ramp(output logic [21:0] px[64]);
    for (int i = 0; i < 64; i++) px[i] = 22'(i);
  endfunction

  function automatic void rand_frame(output logic [21:0] px[64]);
    for (int i = 0; i < 64; i++) px[i] = 22'($urandom);
  endfunction

  // Present n pixels; mode switches to m1 from pixel toggle_at onwards.
  task automatic drive(input logic [21:0] px[64], input logic m0, input logic m1,
                       input int toggle_at, input int n);
    for (int i = 0; i < n; i++) begin
      int  wait_c;
      bit  acc_f;
      in_valid = 1'b1;
      in_data  = px[i];
      mode     = (i >= toggle_at) ? m1 : m0;
      acc_f    = 1'b0;
      wait_c   = 0;
      while (!acc_f && wait_c < 200) begin
        @(negedge clk);
        acc_f = in_ready;
        @(posedge clk);
        #1;
        wait_c++;
      end
      if (!acc_f) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout pixel=%0d in_ready stayed 0, required 1", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 600) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    fd_hs_idx.delete();
    fd_count = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 22'd0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 22'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b vld=%b data=%h fd=%b required 1 0 0 0",
               in_ready, out_valid, out_data, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_max_ramp();
    logic [21:0] px[64];
    logic [21:0] res[16];
    clear_log();
    ramp(px);
    model_frame(px, 1'b0, res);
    drive(px, 1'b0, 1'b0, 64, 64);
    wait_outputs(16);
    checks++;
    if (got.size() != 16) begin
      failures++; $display("FAIL max_ramp_count got=%0d required 16", got.size());
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k] || res[k] !== 22'(16*(k/4) + 2*(k%4) + 9)) begin
        failures++; $display("FAIL max_ramp[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
    checks++;
    if (fd_count != 1 || fd_hs_idx.size() != 1 || fd_hs_idx[0] != 16) begin
      failures++; $display("FAIL max_ramp_frame_done pulses=%0d required 1 at handshake 16", fd_count);
    end
  endtask

  task automatic test_avg_ramp();
    logic [21:0] px[64];
    logic [21:0] res[16];
    clear_log();
    ramp(px);
    model_frame(px, 1'b1, res);
    drive(px, 1'b1, 1'b1, 64, 64);
    wait_outputs(16);
    checks++;
    if (got.size() != 16) begin
      failures++; $display("FAIL avg_ramp_count got=%0d required 16", got.size());
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k] || res[k] !== 22'(16*(k/4) + 2*(k%4) + 4)) begin
        failures++; $display("FAIL avg_ramp[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
  endtask

  task automatic test_signed();
    logic [21:0] px[64];
    logic [21:0] res[16];
    // Average of {-1,-2,-3,-4}.
    clear_log();
    rand_frame(px);
    px[0] = 22'h3FFFFF; px[1] = 22'h3FFFFE; px[8] = 22'h3FFFFD; px[9] = 22'h3FFFFC;
    model_frame(px, 1'b1, res);
    drive(px, 1'b1, 1'b1, 64, 64);
    wait_outputs(16);
    checks++;
    if (got.size() != 16 || got[0] !== 22'h3FFFFD) begin
      failures++; $display("FAIL signed_avg_neg got=%h required 3FFFFD", (got.size() > 0) ? got[0] : 22'h0);
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k]) begin
        failures++; $display("FAIL signed_avg[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
    // Max of {-5,-5,-5,3} and of all -5.
    clear_log();
    rand_frame(px);
    px[0] = 22'h3FFFFB; px[1] = 22'h3FFFFB; px[8] = 22'h3FFFFB; px[9] = 22'd3;
    px[2] = 22'h3FFFFB; px[3] = 22'h3FFFFB; px[10] = 22'h3FFFFB; px[11] = 22'h3FFFFB;
    model_frame(px, 1'b0, res);
    drive(px, 1'b0, 1'b0, 64, 64);
    wait_outputs(16);
    checks++;
    if (got.size() != 16 || got[0] !== 22'd3 || got[1] !== 22'h3FFFFB) begin
      failures++; $display("FAIL signed_max_neg got=%h,%h required 000003,3FFFFB",
                           (got.size() > 0) ? got[0] : 22'h0, (got.size() > 1) ? got[1] : 22'h0);
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k]) begin
        failures++; $display("FAIL signed_max[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] px[64];
    logic [21:0] res[16];
    clear_log();
    ramp(px);
    model_frame(px, 1'b0, res);
    out_ready = 1'b0;
    fork
      drive(px, 1'b0, 1'b0, 64, 64);
      begin
        int c;
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 300) begin @(negedge clk); c++; end
        for (int s = 0; s < 10; s++) begin
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 22'd9) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got rdy=%b vld=%b data=%h required 0 1 000009",
                     s, in_ready, out_valid, out_data);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(16);
    checks++;
    if (got.size() != 16 || fd_count != 1) begin
      failures++; $display("FAIL stall_count got=%0d fd=%0d required 16 1", got.size(), fd_count);
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k]) begin
        failures++; $display("FAIL stall_seq[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [21:0] px[64];
    logic [21:0] res[16];
    clear_log();
    ramp(px);
    drive(px, 1'b0, 1'b0, 64, 20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      failures++; $display("FAIL midframe_reset got vld=%b rdy=%b fd=%b required 0 1 0",
                           out_valid, in_ready, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    model_frame(px, 1'b0, res);
    drive(px, 1'b0, 1'b0, 64, 64);
    wait_outputs(16);
    checks++;
    if (got.size() != 16 || fd_count != 1) begin
      failures++; $display("FAIL post_reset_count got=%0d fd=%0d required 16 1", got.size(), fd_count);
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== res[k]) begin
        failures++; $display("FAIL post_reset[%0d] got=%h required %h", k, got[k], res[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] px[64];
    logic [21:0] res_a[16];
    logic [21:0] res_b[16];
    clear_log();
    ramp(px);
    model_frame(px, 1'b0, res_a);
    model_frame(px, 1'b1, res_b);
    drive(px, 1'b0, 1'b1, 30, 64);
    drive(px, 1'b1, 1'b1, 64, 64);
    wait_outputs(32);
    checks++;
    if (got.size() != 32 || fd_count != 2 || fd_hs_idx.size() != 2 ||
        fd_hs_idx[0] != 16 || fd_hs_idx[1] != 32) begin
      failures++; $display("FAIL b2b_count got=%0d fd=%0d required 32 2", got.size(), fd_count);
    end
    for (int k = 0; k < 32 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== ((k < 16) ? res_a[k] : res_b[k-16])) begin
        failures++; $display("FAIL b2b[%0d] got=%h required %h", k, got[k],
                             (k < 16) ? res_a[k] : res_b[k-16]);
      end
    end
  endtask

  task automatic test_random();
    logic [21:0] px_a[64];
    logic [21:0] px_b[64];
    logic [21:0] res_a[16];
    logic [21:0] res_b[16];
    logic        m_a;
    logic        m_b;
    bit          done;
    clear_log();
    rand_frame(px_a);
    rand_frame(px_b);
    m_a = 1'($urandom_range(0, 1));
    m_b = ~m_a;
    model_frame(px_a, m_a, res_a);
    model_frame(px_b, m_b, res_b);
    done = 1'b0;
    fork
      begin
        drive(px_a, m_a, m_a, 64, 64);
        drive(px_b, m_b, m_b, 64, 64);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(32);
    checks++;
    if (got.size() != 32 || fd_count != 2) begin
      failures++; $display("FAIL rand_count got=%0d fd=%0d required 32 2", got.size(), fd_count);
    end
    for (int k = 0; k < 32 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== ((k < 16) ? res_a[k] : res_b[k-16])) begin
        failures++; $display("FAIL rand[%0d] got=%h required %h", k, got[k],
                             (k < 16) ? res_a[k] : res_b[k-16]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fd_count = 0;
    test_reset();
    test_max_ramp();
    test_avg_ramp();
    test_signed();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
